rptr_empty_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 13 +
 rtl/rptr_empty_ctrl_if.sv | 27 ++
 rtl/fifo_gray2bin.sv | 13 +
 rtl/rptr_empty_ctrl.sv | 86 ++++++++
 tb/tb_rptr_empty_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width, pointer type and binary-to-Gray helper.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH = 9;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rptr_empty_ctrl_if.sv
// Read-side handshake/status bundle of the async FIFO.
// The master drives the read request and the synchronized write pointer; the slave reports the status.
interface rptr_empty_ctrl_if;
  import fifo_pkg::*;

  logic                  r_en;
  ptr_t                  wptr_gray_sync;
  ptr_t                  rptr;
  ptr_t                  rptr_gray;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  f_empty;
  logic                  f_aempty;
  ptr_t                  rd_count;
  logic                  r_valid;
  logic                  underflow;

  modport master (
    output r_en, wptr_gray_sync,
    input  rptr, rptr_gray, raddr, f_empty, f_aempty, rd_count, r_valid, underflow
  );

  modport slave (
    input  r_en, wptr_gray_sync,
    output rptr, rptr_gray, raddr, f_empty, f_aempty, rd_count, r_valid, underflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
  parameter int W = 10
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and empty/almost-empty/occupancy controller of the async FIFO.
// Optional feature macro: RPTR_UNDERFLOW_CHK_EN builds the sticky underflow flag and its assertion.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int AE_THRESH = 4
) (
  input  logic              r_clk,
  input  logic              rrst_n,
  rptr_empty_ctrl_if.slave  bus
);

  ptr_t rptr_q;
  ptr_t rgray_q;
  ptr_t count_q;
  logic empty_q;
  logic aempty_q;
  logic valid_q;

  ptr_t wbin;
  ptr_t rptr_next;
  ptr_t rgray_next;
  ptr_t cnt_next;
  logic rd_acc;

  fifo_gray2bin #(
    .W (ADDR_WIDTH + 1)
  ) u_wptr_g2b (
    .gray (bus.wptr_gray_sync),
    .bin  (wbin)
  );

  // Status is computed from the next pointer so that a read and a synced write in the
  // same cycle are both reflected one cycle later.
  assign rd_acc     = bus.r_en && !empty_q;
  assign rptr_next  = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
  assign rgray_next = bin2gray(rptr_next);
  assign cnt_next   = wbin - rptr_next;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_q   <= '0;
      rgray_q  <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      rptr_q   <= rptr_next;
      rgray_q  <= rgray_next;
      count_q  <= cnt_next;
      empty_q  <= (rgray_next == bus.wptr_gray_sync);
      aempty_q <= (cnt_next <= ptr_t'(AE_THRESH));
      valid_q  <= rd_acc;
    end
  end

  assign bus.rptr      = rptr_q;
  assign bus.rptr_gray = rgray_q;
  assign bus.raddr     = rptr_q[ADDR_WIDTH-1:0];
  assign bus.f_empty   = empty_q;
  assign bus.f_aempty  = aempty_q;
  assign bus.rd_count  = count_q;
  assign bus.r_valid   = valid_q;

`ifdef RPTR_UNDERFLOW_CHK_EN
  logic underflow_q;

  // Sticky until reset so software can see that a read was ever attempted while empty.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      underflow_q <= 1'b0;
    end else if (bus.r_en && empty_q) begin
      underflow_q <= 1'b1;
    end
  end

  assign bus.underflow = underflow_q;

  a_no_underflow : assert property (@(posedge r_clk) disable iff (!rrst_n) !(bus.r_en && empty_q))
    else $warning("rptr_empty_ctrl: read requested while FIFO empty");
`else
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Self-checking bench for rptr_empty_ctrl: directed scenarios plus randomized traffic
// checked against an occupancy-count reference model.
module tb_rptr_empty_ctrl;
  import fifo_pkg::*;

  localparam int AE_THRESH = 4;
  localparam int PTR_MOD   = 2 ** (ADDR_WIDTH + 1);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  logic r_clk  = 1'b0;
  logic rrst_n = 1'b1;

  rptr_empty_ctrl_if bus ();

  rptr_empty_ctrl #(
    .AE_THRESH (AE_THRESH)
  ) dut (
    .r_clk  (r_clk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  always #5 r_clk = ~r_clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: total entries written / read since reset, plus last-cycle flags.
  int wcount;
  int rcount;
  bit exp_empty;
  bit exp_valid;
  bit exp_under;

  function automatic logic [ADDR_WIDTH:0] toGray(input int n);
    int b;
    b = n % PTR_MOD;
    return (ADDR_WIDTH + 1)'(b ^ (b >> 1));
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int occ;
    occ = wcount - rcount;
    checkVal({tag, ".rptr"},      32'(bus.rptr),      32'(rcount % PTR_MOD));
    checkVal({tag, ".rptr_gray"}, 32'(bus.rptr_gray), 32'(toGray(rcount)));
    checkVal({tag, ".raddr"},     32'(bus.raddr),     32'(rcount % DEPTH));
    checkVal({tag, ".f_empty"},   32'(bus.f_empty),   32'(exp_empty));
    checkVal({tag, ".f_aempty"},  32'(bus.f_aempty),  32'(occ <= AE_THRESH));
    checkVal({tag, ".rd_count"},  32'(bus.rd_count),  32'(occ));
    checkVal({tag, ".r_valid"},   32'(bus.r_valid),   32'(exp_valid));
    checkVal({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_under));
  endtask

  // One read-clock cycle: wadd entries become visible through the synchronizer, r_en as given.
  task automatic applyStimulus(input bit en, input int wadd, input string tag);
    bit acc;
    wcount             += wadd;
    bus.r_en           = en;
    bus.wptr_gray_sync = toGray(wcount);
    @(posedge r_clk);
    acc = en && !exp_empty;
`ifdef RPTR_UNDERFLOW_CHK_EN
    if (en && exp_empty) exp_under = 1'b1;
`endif
    rcount    += int'(acc);
    exp_valid = acc;
    exp_empty = (wcount == rcount);
    #1;
    checkOutput(tag);
  endtask

  task automatic modelReset();
    wcount    = 0;
    rcount    = 0;
    exp_empty = 1'b1;
    exp_valid = 1'b0;
    exp_under = 1'b0;
  endtask

  task automatic doReset();
    bus.r_en           = 1'b0;
    bus.wptr_gray_sync = '0;
    rrst_n             = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    rrst_n = 1'b1;
  endtask

  initial begin
    int guard;
    int occ;
    int rdpct;
    int maxw;

    bus.r_en           = 1'b0;
    bus.wptr_gray_sync = '0;
    modelReset();
    #2;

    $display("[TB] reset");
    doReset();
    applyStimulus(1'b0, 0, "idle");

    $display("[TB] single entry");
    applyStimulus(1'b0, 1, "single.write");
    checkVal("single.notempty", 32'(bus.f_empty), 32'd0);
    applyStimulus(1'b1, 0, "single.read");
    checkVal("single.empty", 32'(bus.f_empty), 32'd1);

    $display("[TB] read while empty");
    applyStimulus(1'b1, 0, "uflow.1");
    applyStimulus(1'b1, 0, "uflow.2");
    applyStimulus(1'b0, 0, "uflow.sticky");

    $display("[TB] almost empty");
    doReset();
    applyStimulus(1'b0, 6, "ae.fill");
    checkVal("ae.deassert", 32'(bus.f_aempty), 32'd0);
    applyStimulus(1'b1, 0, "ae.read1");
    applyStimulus(1'b1, 0, "ae.read2");
    checkVal("ae.count4", 32'(bus.rd_count), 32'd4);
    applyStimulus(1'b1, 0, "ae.read3");
    applyStimulus(1'b1, 1, "ae.rdwr");
    applyStimulus(1'b1, 0, "ae.drain1");
    applyStimulus(1'b1, 0, "ae.drain2");
    applyStimulus(1'b1, 0, "ae.drain3");

    $display("[TB] full occupancy");
    applyStimulus(1'b0, DEPTH, "full.fill");
    checkVal("full.count", 32'(bus.rd_count), 32'(DEPTH));

    $display("[TB] pointer wrap");
    doReset();
    guard = 0;
    while (rcount < PTR_MOD - 1 && guard < 4 * PTR_MOD) begin
      applyStimulus(1'b1, (wcount < PTR_MOD) ? 1 : 0, "wrap.run");
      guard++;
    end
    checkVal("wrap.reached", 32'(rcount), 32'(PTR_MOD - 1));
    checkVal("wrap.gray_top", 32'(bus.rptr_gray), 32'h200);
    applyStimulus(1'b1, 0, "wrap.last");
    checkVal("wrap.rptr0", 32'(bus.rptr), 32'd0);
    checkVal("wrap.empty", 32'(bus.f_empty), 32'd1);

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      rdpct = (i < 1000) ? 30 : (i < 2000) ? 85 : 55;
      occ   = wcount - rcount;
      maxw  = DEPTH - occ;
      if (maxw > 3) maxw = 3;
      applyStimulus($urandom_range(0, 99) < rdpct,
                    (maxw > 0) ? int'($urandom_range(0, maxw)) : 0, "rand");
    end

    $display("[TB] reset mid-stream");
    doReset();
    applyStimulus(1'b0, 50, "mid.fill");
    guard = 0;
    while (rcount < 37 && guard < 100) begin
      applyStimulus(1'b1, 0, "mid.read");
      guard++;
    end
    checkVal("mid.at37", 32'(bus.rptr), 32'd37);
    #2;
    rrst_n = 1'b0;
    #1;
    checkVal("mid.rptr",     32'(bus.rptr),      32'd0);
    checkVal("mid.rgray",    32'(bus.rptr_gray), 32'd0);
    checkVal("mid.f_empty",  32'(bus.f_empty),   32'd1);
    checkVal("mid.f_aempty", 32'(bus.f_aempty),  32'd1);
    checkVal("mid.rd_count", 32'(bus.rd_count),  32'd0);
    checkVal("mid.r_valid",  32'(bus.r_valid),   32'd0);
    bus.r_en           = 1'b0;
    bus.wptr_gray_sync = '0;
    modelReset();
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    rrst_n = 1'b1;
    applyStimulus(1'b0, 2, "mid.after");
    applyStimulus(1'b1, 0, "mid.after_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
